// File: rtl/baccarat_deal_ctrl.sv
// rtl/baccarat_deal_ctrl.sv - baccarat hand sequencing FSM (deal strobes, third-card rules, win lights)
//
// Ports:
//   slow_clock        game clock, all state changes on rising edge
//   resetb            synchronous active-low reset
//   pscore, dscore    hand scores 0..9 from the datapath (reflect cards loaded on prior edges)
//   pcard3            player third card code (0 blank, 1 ace, 2..10, 11 J, 12 Q, 13 K)
//   load_pcard1..3    player card slot load strobes
//   load_dcard1..3    dealer card slot load strobes
//   player_win_light  player wins (both lights = tie)
//   dealer_win_light  dealer wins
//   hand_done         high while the hand result is shown

module baccarat_deal_ctrl (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       hand_done
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_P1     = 4'd1,
        S_D1     = 4'd2,
        S_P2     = 4'd3,
        S_D2     = 4'd4,
        S_DECIDE = 4'd5,
        S_P3     = 4'd6,
        S_BANK   = 4'd7,
        S_D3     = 4'd8,
        S_RESULT = 4'd9
    } state_t;

    state_t state, state_next;

    logic [3:0] pcard3_val;
    logic       banker_draws;
    logic       natural;

    // Tens and face cards count zero; blank also maps to zero.
    assign pcard3_val = (pcard3 >= 4'd10) ? 4'd0 : pcard3;

    assign natural = (pscore >= 4'd8) || (dscore >= 4'd8);

    always_comb begin
        banker_draws = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: banker_draws = 1'b1;
            4'd3:             banker_draws = (pcard3_val != 4'd8);
            4'd4:             banker_draws = (pcard3_val >= 4'd2) && (pcard3_val <= 4'd7);
            4'd5:             banker_draws = (pcard3_val >= 4'd4) && (pcard3_val <= 4'd7);
            4'd6:             banker_draws = (pcard3_val >= 4'd6) && (pcard3_val <= 4'd7);
            default:          banker_draws = 1'b0;
        endcase
    end

    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = S_IDLE;
        load_pcard1      = 1'b0;
        load_pcard2      = 1'b0;
        load_pcard3      = 1'b0;
        load_dcard1      = 1'b0;
        load_dcard2      = 1'b0;
        load_dcard3      = 1'b0;
        player_win_light = 1'b0;
        dealer_win_light = 1'b0;
        hand_done        = 1'b0;
        case (state)
            S_IDLE: state_next = S_P1;
            S_P1: begin
                load_pcard1 = 1'b1;
                state_next  = S_D1;
            end
            S_D1: begin
                load_dcard1 = 1'b1;
                state_next  = S_P2;
            end
            S_P2: begin
                load_pcard2 = 1'b1;
                state_next  = S_D2;
            end
            S_D2: begin
                load_dcard2 = 1'b1;
                state_next  = S_DECIDE;
            end
            S_DECIDE: begin
                if (natural)                state_next = S_RESULT;
                else if (pscore <= 4'd5)    state_next = S_P3;
                else if (dscore <= 4'd5)    state_next = S_D3;
                else                        state_next = S_RESULT;
            end
            S_P3: begin
                load_pcard3 = 1'b1;
                state_next  = S_BANK;
            end
            // pcard3 and the updated player score are only valid here.
            S_BANK: state_next = banker_draws ? S_D3 : S_RESULT;
            S_D3: begin
                load_dcard3 = 1'b1;
                state_next  = S_RESULT;
            end
            S_RESULT: begin
                hand_done        = 1'b1;
                player_win_light = (pscore >= dscore);
                dealer_win_light = (dscore >= pscore);
                state_next       = S_RESULT;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule
